// File: rtl/spi_pkg.sv
// Register map, status/control bit positions and FSM states
// shared by the SPI slave responder and its submodules.
package spi_pkg;

    localparam int SPI_DATABITS = 8;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int ST_E    = 8;
    localparam int ST_RRDY = 7;
    localparam int ST_TRDY = 6;
    localparam int ST_BUSY = 5;
    localparam int ST_TUR  = 4;
    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 2;

    // Interrupt enables sit at the same positions as the status bits they gate.
    localparam int CTL_IE_E    = ST_E;
    localparam int CTL_IE_RRDY = ST_RRDY;
    localparam int CTL_IE_TRDY = ST_TRDY;
    localparam int CTL_IE_TUR  = ST_TUR;
    localparam int CTL_IE_ROE  = ST_ROE;

    localparam logic [15:0] IRQ_MASK = (16'd1 << CTL_IE_E)
                                     | (16'd1 << CTL_IE_RRDY)
                                     | (16'd1 << CTL_IE_TRDY)
                                     | (16'd1 << CTL_IE_TUR)
                                     | (16'd1 << CTL_IE_ROE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an idle-high bus line with rise/fall pulses.
// Edges are suppressed until the chain holds only post-reset samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic [STAGES:0]   fill;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            fill <= '0;
            prev <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            fill <= {fill[STAGES-1:0], 1'b1};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = fill[STAGES] & q & ~prev;
    assign fall = fill[STAGES] & ~q & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-3 slave with a CPU register port for rx/tx data,
// status flags, interrupt enables and a registered irq.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DATABITS    = SPI_DATABITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int CW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATABITS - 1);

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(SCLK),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .reset(reset), .d(SS_n),
        .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .d(MOSI),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t          state;
    logic [DATABITS-1:0] shift_tx, shift_rx, tx_holding, rx_holding;
    logic [CW-1:0]       bit_count;
    logic                tx_primed, rrdy, roe, tur, toe, miso_r;
    logic [15:0]         control, status, rd_data;
    logic                wr_en, rd_en, rd_rx, frame_done, load_tx;

    assign wr_en      = spi_select & ~write_n;
    assign rd_en      = spi_select & ~read_n;
    assign rd_rx      = rd_en && (mem_addr == ADDR_RXDATA);
    assign frame_done = (state == S_SHIFT) && !ss_rise && sclk_rise
                        && (bit_count == LAST);
    assign load_tx    = ((state == S_IDLE) && ss_fall)
                        || ((state == S_LOAD) && !ss_rise);

    always_comb begin
        status          = '0;
        status[ST_E]    = roe | tur | toe;
        status[ST_RRDY] = rrdy;
        status[ST_TRDY] = ~tx_primed;
        status[ST_BUSY] = ~ss_q;
        status[ST_TUR]  = tur;
        status[ST_ROE]  = roe;
        status[ST_TOE]  = toe;
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            mem_addr == ADDR_RXDATA:  rd_data[DATABITS-1:0] = rx_holding;
            mem_addr == ADDR_STATUS:  rd_data = status;
            mem_addr == ADDR_CONTROL: rd_data = control;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shift_tx    <= '0;
            shift_rx    <= '0;
            tx_holding  <= '0;
            rx_holding  <= '0;
            bit_count   <= '0;
            tx_primed   <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            tur         <= 1'b0;
            toe         <= 1'b0;
            control     <= '0;
            irq         <= 1'b0;
            data_to_cpu <= '0;
            miso_r      <= 1'b1;
            MISO_oe     <= 1'b0;
        end else begin
            if (rd_en)
                data_to_cpu <= rd_data;
            irq <= |(control & status & IRQ_MASK);
            if (rd_rx)
                rrdy <= 1'b0;
            if (wr_en && mem_addr == ADDR_CONTROL)
                control <= data_from_cpu;
            // Error sets below override a same-cycle status-write clear.
            if (wr_en && mem_addr == ADDR_STATUS) begin
                roe <= 1'b0;
                tur <= 1'b0;
                toe <= 1'b0;
            end
            if (load_tx) begin
                if (tx_primed) begin
                    shift_tx  <= tx_holding;
                    tx_primed <= 1'b0;
                end else begin
                    shift_tx <= '0;
                    tur      <= 1'b1;
                end
            end
            if (wr_en && mem_addr == ADDR_TXDATA) begin
                if (tx_primed) begin
                    toe <= 1'b1;
                end else begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    tx_primed  <= 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        state     <= S_SHIFT;
                        bit_count <= '0;
                        MISO_oe   <= 1'b1;
                        miso_r    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (ss_rise) begin
                        state     <= S_IDLE;
                        bit_count <= '0;
                        MISO_oe   <= 1'b0;
                        miso_r    <= 1'b1;
                    end else begin
                        if (sclk_fall) begin
                            miso_r   <= shift_tx[DATABITS-1];
                            shift_tx <= shift_tx << 1;
                        end
                        if (sclk_rise) begin
                            shift_rx  <= {shift_rx[DATABITS-2:0], mosi_q};
                            bit_count <= bit_count + 1'b1;
                        end
                        if (frame_done) begin
                            rx_holding <= {shift_rx[DATABITS-2:0], mosi_q};
                            rrdy       <= 1'b1;
                            if (rrdy && !rd_rx)
                                roe <= 1'b1;
                            bit_count  <= '0;
                            state      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (ss_rise) begin
                        state   <= S_IDLE;
                        MISO_oe <= 1'b0;
                        miso_r  <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign MISO          = MISO_oe ? miso_r : 1'b1;
    assign dataavailable = rrdy;
    assign readyfordata  = ~tx_primed;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed and randomized bench for the SPI slave responder,
// checked against a transaction-level model of the register file.
module tb_spi_slave_responder;

    localparam int HALF = 78;

    logic        clk = 1'b0;
    logic        reset, SCLK, SS_n, MOSI;
    logic        MISO, MISO_oe;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        irq, dataavailable, readyfordata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_hold, m_rx, m_cur;
    logic        m_primed, m_rrdy, m_roe, m_tur, m_toe;
    logic [15:0] m_ctrl;

    always #5 clk = ~clk;

    spi_slave_responder dut (
        .clk(clk), .reset(reset),
        .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe),
        .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
        .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq),
        .dataavailable(dataavailable), .readyfordata(readyfordata)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic m_reset();
        m_hold = 0; m_rx = 0; m_cur = 0; m_primed = 0;
        m_rrdy = 0; m_roe = 0; m_tur = 0; m_toe = 0; m_ctrl = 0;
    endtask

    function automatic logic [15:0] m_status(input logic busy);
        logic [15:0] s;
        s = 16'h0;
        s[8] = m_roe | m_tur | m_toe;
        s[7] = m_rrdy;
        s[6] = ~m_primed;
        s[5] = busy;
        s[4] = m_tur;
        s[3] = m_roe;
        s[2] = m_toe;
        return s;
    endfunction

    function automatic logic m_irq();
        return |(m_ctrl & m_status(1'b0) & 16'h01D8);
    endfunction

    task automatic m_load();
        if (m_primed) begin
            m_cur = m_hold;
            m_primed = 0;
        end else begin
            m_cur = 8'h00;
            m_tur = 1;
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        spi_select = 0; write_n = 1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1; read_n = 0; mem_addr = a;
        @(negedge clk);
        spi_select = 0; read_n = 1;
        d = data_to_cpu;
    endtask

    task automatic tx_write(input logic [7:0] d);
        cpu_write(3'd1, {8'h00, d});
        if (m_primed) m_toe = 1;
        else begin m_hold = d; m_primed = 1; end
    endtask

    task automatic ctrl_write(input logic [15:0] d);
        cpu_write(3'd3, d);
        m_ctrl = d;
    endtask

    task automatic status_clear();
        cpu_write(3'd2, 16'hFFFF);
        m_roe = 0; m_tur = 0; m_toe = 0;
    endtask

    task automatic rx_read(input string tag);
        logic [15:0] d;
        cpu_read(3'd0, d);
        check(tag, d, {8'h00, m_rx});
        m_rrdy = 0;
    endtask

    task automatic status_check(input string tag, input logic busy);
        logic [15:0] d;
        cpu_read(3'd2, d);
        check(tag, d, m_status(busy));
    endtask

    task automatic ss_fall_t();
        SS_n = 0;
        m_load();
        #(HALF);
    endtask

    task automatic ss_rise_t();
        #(HALF);
        SS_n = 1;
        #(4*HALF);
    endtask

    task automatic clock_bits(input logic [7:0] mo, input int n,
                              output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            SCLK = 0; MOSI = mo[7-i];
            #(HALF);
            mi = {mi[6:0], MISO};
            SCLK = 1;
            #(HALF);
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] mo);
        logic [7:0] mi, want;
        want = m_cur;
        clock_bits(mo, 8, mi);
        check(tag, {8'h00, mi}, {8'h00, want});
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1;
        m_rx = mo;
        m_load();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  b0, b1, mi;
        logic [15:0] d;

        reset = 1; SCLK = 1; SS_n = 1; MOSI = 1;
        spi_select = 0; read_n = 1; write_n = 1;
        mem_addr = 0; data_from_cpu = 0;
        m_reset();
        #23;
        check("rst MISO", {15'h0, MISO}, 16'h1);
        check("rst MISO_oe", {15'h0, MISO_oe}, 16'h0);
        check("rst irq", {15'h0, irq}, 16'h0);
        check("rst data_to_cpu", data_to_cpu, 16'h0);
        check("rst dataavailable", {15'h0, dataavailable}, 16'h0);
        reset = 0;
        wait_clks(10);
        status_check("rst status", 1'b0);
        cpu_read(3'd3, d);
        check("rst control", d, 16'h0);

        // Basic A5 out / 3C in
        tx_write(8'hA5);
        check("t1 trdy", {15'h0, readyfordata}, {15'h0, ~m_primed});
        ss_fall_t();
        check("t1 oe", {15'h0, MISO_oe}, 16'h1);
        frame("t1 miso", 8'h3C);
        ss_rise_t();
        check("t1 oe off", {15'h0, MISO_oe}, 16'h0);
        check("t1 miso idle", {15'h0, MISO}, 16'h1);
        check("t1 rrdy", {15'h0, dataavailable}, 16'h1);
        rx_read("t1 rx");
        check("t1 rrdy clr", {15'h0, dataavailable}, 16'h0);
        status_check("t1 status", 1'b0);
        status_clear();
        status_check("t1 status clr", 1'b0);

        // Back-to-back frames, no second tx write
        b0 = 8'($urandom);
        tx_write(b0);
        ss_fall_t();
        frame("t2 miso0", 8'($urandom));
        frame("t2 miso1 zero", 8'($urandom));
        ss_rise_t();
        status_check("t2 status", 1'b0);
        rx_read("t2 rx");
        status_clear();

        // Overrun with ROE interrupt enabled
        ctrl_write(16'h0008);
        ss_fall_t(); frame("t3 miso0", 8'($urandom)); ss_rise_t();
        ss_fall_t(); frame("t3 miso1", 8'($urandom)); ss_rise_t();
        status_check("t3 status", 1'b0);
        check("t3 irq", {15'h0, irq}, 16'h1);
        rx_read("t3 rx second");
        status_clear();
        ctrl_write(16'h0000);
        wait_clks(2);
        check("t3 irq clr", {15'h0, irq}, {15'h0, m_irq()});

        // Double tx write before frame
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        tx_write(b0);
        tx_write(b1);
        status_check("t4 toe", 1'b0);
        ss_fall_t(); frame("t4 first byte", 8'($urandom)); ss_rise_t();
        rx_read("t4 rx");
        status_clear();
        status_check("t4 status clr", 1'b0);

        // Partial frame aborted by SS_n rise
        tx_write(8'($urandom));
        ss_fall_t();
        clock_bits(8'($urandom), 5, mi);
        ss_rise_t();
        check("t5 oe", {15'h0, MISO_oe}, 16'h0);
        check("t5 rrdy", {15'h0, dataavailable}, {15'h0, m_rrdy});
        ss_fall_t(); frame("t5 miso", 8'($urandom)); ss_rise_t();
        rx_read("t5 rx");
        status_clear();

        // Randomized single frames with random enables
        for (int it = 0; it < 6; it++) begin
            ctrl_write(16'($urandom) & 16'h01D8);
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            ss_fall_t(); frame("rnd miso", 8'($urandom)); ss_rise_t();
            if ($urandom_range(0, 1) == 1) rx_read("rnd rx");
            status_check("rnd status", 1'b0);
            wait_clks(2);
            check("rnd irq", {15'h0, irq}, {15'h0, m_irq()});
            if ($urandom_range(0, 2) == 0) status_clear();
        end

        // Reset mid-frame
        ctrl_write(16'h0048);
        cpu_read(3'd3, d);
        tx_write(8'($urandom));
        ss_fall_t();
        clock_bits(8'($urandom), 3, mi);
        #3 reset = 1;
        #1;
        check("t6 oe", {15'h0, MISO_oe}, 16'h0);
        check("t6 MISO", {15'h0, MISO}, 16'h1);
        check("t6 irq", {15'h0, irq}, 16'h0);
        check("t6 data_to_cpu", data_to_cpu, 16'h0);
        check("t6 rrdy", {15'h0, dataavailable}, 16'h0);
        check("t6 trdy", {15'h0, readyfordata}, 16'h1);
        m_reset();
        #200 reset = 0;
        wait_clks(30);
        check("t6 no frame", {15'h0, MISO_oe}, 16'h0);
        status_check("t6 status busy", 1'b1);
        cpu_read(3'd3, d);
        check("t6 control", d, 16'h0);
        SS_n = 1;
        #(4*HALF);
        tx_write(8'($urandom));
        ss_fall_t(); frame("t6 miso", 8'($urandom)); ss_rise_t();
        rx_read("t6 rx");
        status_check("t6 status", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
